alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OPW, default 3, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-007 reqN_A, reqN_B  input  WIDTH  requester N operands.
REQ-008 reqN_op  input  OPW  requester N ALU operation code.
REQ-009 respN_valid  output  1  result for requester N held valid.
REQ-010 respN_res  output  WIDTH  registered result for requester N.
REQ-011 respN_zero, respN_co  output  1  registered zero / carry-out flags.
REQ-012 respN_ack  input  1  requester N consumes its response.
REQ-013 alu_A, alu_B  output  WIDTH  operands driven to the shared ALU.
REQ-014 alu_op  output  OPW  operation code driven to the shared ALU.
REQ-015 alu_res  input  WIDTH; alu_zero, alu_co  input  1  combinational ALU outputs.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any reqN_valid, grant one requester, latch its A/B/op, pulse its reqN_ready for that cycle, go to EXEC; else stay.
REQ-019 Both valid in IDLE: grant requester indicated by priority pointer; loser's ready stays 0, its request remains pending.
REQ-020 Priority pointer SHALL flip to the non-granted requester on each completed transaction (round-robin); a lone requester is granted regardless of pointer.
REQ-021 reqN_ready SHALL be asserted only in IDLE, only for the granted requester, combinationally from valid and pointer.
REQ-022 EXEC: alu_A/alu_B/alu_op SHALL equal latched values; alu_res/zero/co captured into respN registers at cycle end; go to RESP.
REQ-023 Outside EXEC, alu_A/alu_B/alu_op SHALL hold last latched values (no glitching to requester inputs).
REQ-024 RESP: respN_valid of the granted requester held high with stable data until respN_ack=1, then go to IDLE same edge.
REQ-025 Latency: accept in cycle T, respN_valid high in cycle T+2; minimum 3 cycles per transaction.
REQ-026 Ack on a requester with respN_valid=0 SHALL be ignored; the other requester's respN_valid SHALL stay 0.
REQ-027 reqN_valid dropped before ready: no transaction, no state change.
REQ-028 All 2^OPW op codes SHALL pass through unmodified; the block does not interpret them.

Reset
REQ-029 rst=1 SHALL force IDLE, all respN_valid/reqN_ready/busy 0, respN_res/zero/co 0, alu_A/alu_B/alu_op 0, pointer to requester 0.
REQ-030 Reset mid-transaction (EXEC or RESP) SHALL discard it silently; no response delivered after reset.

Structure
REQ-031 Shared package alu_arb_pkg SHALL hold state encoding, WIDTH/OPW defaults and op-code constants (AND=0, OR=1, ADD=2, XOR=3, NOR=4, SRL=5, SUB=6, SLT=7).
REQ-032 Two-way round-robin grant logic SHALL be sub-module rr_arbiter2 (inputs valid[1:0], pointer; output one-hot grant).
REQ-033 Shared ALU instantiated outside this block; connects only via alu_* ports.

Verification
REQ-034 After reset, req0 A=5,B=3,op=ADD -> req0_ready cycle T, resp0_valid at T+2 with res=8, zero=0; held until ack.
REQ-035 Both valid same cycle post-reset, req1 SUB 7-7 -> req0 granted first; after ack req1 granted, resp1 res=0, zero=1.
REQ-036 Both valid continuously, 4 transactions -> grants alternate 0,1,0,1; no starvation.
REQ-037 resp0_valid held, ack withheld 10 cycles, req1 valid -> resp0 stable, req1_ready 0, busy 1 throughout.
REQ-038 rst asserted during EXEC -> next cycle IDLE, all outputs 0, no respN_valid afterwards.
REQ-039 SLT A=0xFFFFFFFF, B=1 via req1 -> resp1 res=1; stray resp0_ack ignored.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU share arbiter:
// FSM state encoding, default widths and ALU op-code constants.
package alu_arb_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: one-hot grant from valid[1:0].
// Ports: valid (requests), ptr (favoured requester on a tie), grant (one-hot or zero).
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters, one transaction at a time.
// Ports: clk/rst, req0/req1 (valid/ready/A/B/op), resp0/resp1 (valid/res/zero/co/ack),
//        alu_A/alu_B/alu_op to the ALU, alu_res/alu_zero/alu_co back, busy.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [OPW-1:0]   req1_op,

    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_res,
    output logic             resp0_zero,
    output logic             resp0_co,
    input  logic             resp0_ack,

    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_res,
    output logic             resp1_zero,
    output logic             resp1_co,
    input  logic             resp1_ack,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_co,

    output logic             busy
);

    logic [1:0] state;
    logic       ptr;
    logic       owner;
    logic [1:0] grant;
    logic       idle_ok;
    logic       own_ack;

    rr_arbiter2 u_rr (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign idle_ok    = (state == ST_IDLE) && !rst;
    assign req0_ready = idle_ok && grant[0];
    assign req1_ready = idle_ok && grant[1];

    assign busy        = (state != ST_IDLE);
    assign resp0_valid = (state == ST_RESP) && !owner;
    assign resp1_valid = (state == ST_RESP) && owner;

    // Only the owner's ack counts; a stray ack from the other side is ignored.
    assign own_ack = owner ? resp1_ack : resp0_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_op     <= '0;
            resp0_res  <= '0;
            resp0_zero <= 1'b0;
            resp0_co   <= 1'b0;
            resp1_res  <= '0;
            resp1_zero <= 1'b0;
            resp1_co   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Operands stay latched afterwards so the ALU inputs
                    // never follow the live requester buses.
                    if (|grant) begin
                        owner  <= grant[1];
                        alu_A  <= grant[1] ? req1_A  : req0_A;
                        alu_B  <= grant[1] ? req1_B  : req0_B;
                        alu_op <= grant[1] ? req1_op : req0_op;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (owner) begin
                        resp1_res  <= alu_res;
                        resp1_zero <= alu_zero;
                        resp1_co   <= alu_co;
                    end else begin
                        resp0_res  <= alu_res;
                        resp0_zero <= alu_zero;
                        resp0_co   <= alu_co;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (own_ack) begin
                        ptr   <= ~owner;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
